// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and helpers.
// Used by the scan controller and any other display block.
package seg7_pkg;

    localparam int MAX_DIGITS = 16;

    // Segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Bit d set when nibble d and all nibbles above it are zero.
    // The rightmost digit is never flagged.
    function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(
        input logic [4*MAX_DIGITS-1:0] data,
        input int                      n_digits,
        input logic                    en
    );
        logic                  run;
        logic [MAX_DIGITS-1:0] mask;
        run  = 1'b1;
        mask = '0;
        for (int d = MAX_DIGITS - 1; d >= 0; d--) begin
            if (d < n_digits) begin
                run     = run & (data[4*d +: 4] == 4'h0);
                mask[d] = en & run & (d != 0);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display register side and pin side of the scan controller.
// master = CPU/register side, slave = the controller.
interface seg7_scan_ctrl_if #(
    parameter int N_DIGITS = 8
);
    logic [4*N_DIGITS-1:0] data;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  lzb;
    logic [3:0]            bright;
    logic [N_DIGITS-1:0]   num_scan_select;
    logic [7:0]            num_seg7;

    modport master (
        output data, dp, digit_en, lzb, bright,
        input  num_scan_select, num_seg7
    );

    modport slave (
        input  data, dp, digit_en, lzb, bright,
        output num_scan_select, num_seg7
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Hex nibble plus decimal point to {dp,a,b,c,d,e,f,g}.
// Pure combinational, active-high segments.
import seg7_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = {dp, SEG_TABLE[nibble]};
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan driver with blanking guard, PWM dimming,
// per-digit enable/dp, leading-zero blanking and per-frame snapshot.
import seg7_pkg::*;

module seg7_scan_ctrl #(
    parameter int N_DIGITS       = 8,
    parameter int DIV_CNT        = 150000,
    parameter int BLANK_CYC      = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int TW = $clog2(DIV_CNT);
    localparam int SW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW = 4 * N_DIGITS;
    localparam logic [7:0] POL = {8{SEG_ACTIVE_LOW}};
    localparam logic [7:0] OFF = SEG_BLANK ^ POL;

    logic [TW-1:0]       tick_cnt;
    logic [SW-1:0]       slot;
    logic [3:0]          pwm_cnt;
    logic [DW-1:0]       snap_data;
    logic [N_DIGITS-1:0] snap_dp;
    logic [N_DIGITS-1:0] snap_en;
    logic                snap_lzb;
    logic [3:0]          snap_bright;

    logic [DW-1:0]         cur_data;
    logic [N_DIGITS-1:0]   cur_dp;
    logic [N_DIGITS-1:0]   cur_en;
    logic                  cur_lzb;
    logic [3:0]            cur_bright;
    logic [MAX_DIGITS-1:0] lz_mask;
    logic [SW-1:0]         dig;
    logic [3:0]            nibble;
    logic [7:0]            dec_seg;
    logic                  frame_start;
    logic                  lit;
    logic [N_DIGITS-1:0]   sel_q;
    logic [7:0]            seg_q;

    assign frame_start = (tick_cnt == '0) && (slot == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            slot     <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (tick_cnt == TW'(DIV_CNT - 1)) begin
                tick_cnt <= '0;
                if (slot == SW'(N_DIGITS - 1))
                    slot <= '0;
                else
                    slot <= slot + SW'(1);
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_data   <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_lzb    <= 1'b0;
            snap_bright <= '0;
        end else if (frame_start) begin
            snap_data   <= bus.data;
            snap_dp     <= bus.dp;
            snap_en     <= bus.digit_en;
            snap_lzb    <= bus.lzb;
            snap_bright <= bus.bright;
        end
    end

    // The frame-start cycle already renders the values being latched.
    always_comb begin
        cur_data   = snap_data;
        cur_dp     = snap_dp;
        cur_en     = snap_en;
        cur_lzb    = snap_lzb;
        cur_bright = snap_bright;
        if (frame_start) begin
            cur_data   = bus.data;
            cur_dp     = bus.dp;
            cur_en     = bus.digit_en;
            cur_lzb    = bus.lzb;
            cur_bright = bus.bright;
        end
    end

    always_comb begin
        dig     = SW'(N_DIGITS - 1) - slot;
        nibble  = cur_data[{dig, 2'b00} +: 4];
        lz_mask = lead_zero_mask(64'(cur_data), N_DIGITS, cur_lzb);
        lit     = (tick_cnt >= TW'(BLANK_CYC))
                && (pwm_cnt <= cur_bright)
                && cur_en[dig]
                && !lz_mask[dig];
    end

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .dp     (cur_dp[dig]),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst || !lit) begin
            sel_q <= '1;
            seg_q <= OFF;
        end else begin
            sel_q <= ~(N_DIGITS'(1) << dig);
            seg_q <= dec_seg ^ POL;
        end
    end

    assign bus.num_scan_select = sel_q;
    assign bus.num_seg7        = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: per-frame reference model plus
// scenario tasks; an active-low twin checks output inversion.
module tb_seg7_scan_ctrl;
    localparam int N     = 8;
    localparam int DIV   = 40;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        lzb;
    logic [3:0]  bright;

    int checks   = 0;
    int failures = 0;

    seg7_scan_ctrl_if #(.N_DIGITS(N)) bus ();
    seg7_scan_ctrl_if #(.N_DIGITS(N)) bus_al ();

    assign bus.data        = data;
    assign bus.dp          = dp;
    assign bus.digit_en    = en;
    assign bus.lzb         = lzb;
    assign bus.bright      = bright;
    assign bus_al.data     = data;
    assign bus_al.dp       = dp;
    assign bus_al.digit_en = en;
    assign bus_al.lzb      = lzb;
    assign bus_al.bright   = bright;

    seg7_scan_ctrl #(
        .N_DIGITS(N), .DIV_CNT(DIV), .BLANK_CYC(BLANK),
        .SEG_ACTIVE_LOW(1'b0)
    ) u_dut (.clk(clk), .rst(rst), .bus(bus));

    seg7_scan_ctrl #(
        .N_DIGITS(N), .DIV_CNT(DIV), .BLANK_CYC(BLANK),
        .SEG_ACTIVE_LOW(1'b1)
    ) u_dut_al (.clk(clk), .rst(rst), .bus(bus_al));

    always #5 clk = ~clk;

    // Reference model: k = cycles since reset release.
    logic [6:0]  seg_ref [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };
    int unsigned k;
    int          obs_slot;
    int          obs_tick;
    logic [7:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic [31:0] s_data;
    logic [7:0]  s_dp, s_en;
    logic        s_lzb;
    logic [3:0]  s_br;

    always @(posedge clk) begin : model
        int  tick, slot, pwm, d;
        bit  lz, lit;
        if (rst) begin
            k = 0; obs_slot = -1; obs_tick = -1;
            s_data = 0; s_dp = 0; s_en = 0; s_lzb = 0; s_br = 0;
            exp_sel = 8'hFF; exp_seg = 8'h00;
        end else begin
            if (k % FRAME == 0) begin
                s_data = data; s_dp = dp; s_en = en;
                s_lzb = lzb; s_br = bright;
            end
            tick = k % DIV;
            slot = (k / DIV) % N;
            pwm  = k % 16;
            d    = N - 1 - slot;
            lz   = s_lzb && d > 0 && (s_data >> (4 * d)) == 32'd0;
            lit  = tick >= BLANK && pwm <= s_br && s_en[d] && !lz;
            exp_sel  = lit ? ~(8'd1 << d) : 8'hFF;
            exp_seg  = lit ? {s_dp[d], seg_ref[s_data[4*d +: 4]]} : 8'h00;
            obs_slot = slot;
            obs_tick = tick;
            k++;
        end
    end

    // Per-slot observation record (not a check)
    logic [7:0] rec_sel [8];
    logic [7:0] rec_seg [8];
    logic [7:0] rec_al  [8];
    int         rec_lit [8];
    int         rec_blank;

    always @(negedge clk) begin
        if (!rst && obs_slot >= 0) begin
            if (bus.num_scan_select !== 8'hFF) begin
                rec_lit[obs_slot]++;
                rec_sel[obs_slot] = bus.num_scan_select;
                rec_seg[obs_slot] = bus.num_seg7;
                rec_al[obs_slot]  = bus_al.num_seg7;
            end else if (obs_tick < BLANK) begin
                rec_blank++;
            end
        end
    end

    task automatic clear_rec();
        for (int s = 0; s < 8; s++) begin
            rec_lit[s] = 0; rec_sel[s] = 8'hFF;
            rec_seg[s] = 8'hxx; rec_al[s] = 8'hxx;
        end
        rec_blank = 0;
    endtask

    task automatic wait_frame_start();
        int n = 0;
        while (k % FRAME != 0 && n < FRAME + 4) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (k % FRAME != 0) begin
            failures++;
            $display("FAIL frame_sync: k=%0d not at frame start", k);
        end
        #1;
        clear_rec();
    endtask

    task automatic test_reset();
        int n;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.num_scan_select !== 8'hFF || bus.num_seg7 !== 8'h00
            || bus_al.num_seg7 !== 8'hFF) begin
            failures++;
            $display("FAIL reset_state: sel=%h seg=%h al_seg=%h want FF/00/FF",
                     bus.num_scan_select, bus.num_seg7, bus_al.num_seg7);
        end
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.num_scan_select, bus.num_seg7, bus_al.num_scan_select, bus_al.num_seg7}
                !== {exp_sel, exp_seg, exp_sel, ~exp_seg}) begin
                failures++;
                $display("FAIL reset_model: k=%0d sel=%h seg=%h al_seg=%h want sel=%h seg=%h",
                         k, bus.num_scan_select, bus.num_seg7, bus_al.num_seg7, exp_sel, exp_seg);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.num_scan_select !== 8'hFF || bus.num_seg7 !== 8'h00
                || bus_al.num_seg7 !== 8'hFF) begin
                failures++;
                $display("FAIL mid_reset: sel=%h seg=%h al_seg=%h want FF/00/FF",
                         bus.num_scan_select, bus.num_seg7, bus_al.num_seg7);
            end
        end
        rst = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.num_scan_select !== 8'hFF) break;
        end
        checks++;
        if (n != 3 || bus.num_scan_select !== 8'h7F) begin
            failures++;
            $display("FAIL first_lit: cycle=%0d sel=%h want cycle=3 sel=7F",
                     n, bus.num_scan_select);
        end
    endtask

    task automatic test_decode();
        logic [7:0] want_seg [8] = '{8'h7E, 8'h30, 8'h6D, 8'h79,
                                     8'h7F, 8'h7B, 8'h77, 8'h1F};
        logic [7:0] want_sel [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF,
                                     8'hF7, 8'hFB, 8'hFD, 8'hFE};
        wait_frame_start();
        data = 32'h0123_89AB; bright = 4'd15; dp = 8'h00;
        en = 8'hFF; lzb = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.num_scan_select, bus.num_seg7, bus_al.num_scan_select, bus_al.num_seg7}
                !== {exp_sel, exp_seg, exp_sel, ~exp_seg}) begin
                failures++;
                $display("FAIL decode_model: k=%0d sel=%h seg=%h al_seg=%h want sel=%h seg=%h",
                         k, bus.num_scan_select, bus.num_seg7, bus_al.num_seg7, exp_sel, exp_seg);
            end
        end
        #1;
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (rec_sel[s] !== want_sel[s] || rec_seg[s] !== want_seg[s]) begin
                failures++;
                $display("FAIL decode_slot%0d: sel=%h seg=%h want sel=%h seg=%h",
                         s, rec_sel[s], rec_seg[s], want_sel[s], want_seg[s]);
            end
        end
        checks++;
        if (rec_blank != 2 * N) begin
            failures++;
            $display("FAIL blank_guard: blank cycles=%0d want %0d", rec_blank, 2 * N);
        end
    endtask

    task automatic test_lzb();
        for (int f = 0; f < 2; f++) begin
            wait_frame_start();
            data = (f == 0) ? 32'h0000_0050 : 32'h0;
            lzb = 1'b1; en = 8'hFF; dp = 8'h00; bright = 4'd15;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                checks++;
                if ({bus.num_scan_select, bus.num_seg7, bus_al.num_scan_select, bus_al.num_seg7}
                    !== {exp_sel, exp_seg, exp_sel, ~exp_seg}) begin
                    failures++;
                    $display("FAIL lzb_model: k=%0d sel=%h seg=%h want sel=%h seg=%h",
                             k, bus.num_scan_select, bus.num_seg7, exp_sel, exp_seg);
                end
            end
            #1;
            for (int s = 0; s < 6; s++) begin
                checks++;
                if (rec_lit[s] != 0) begin
                    failures++;
                    $display("FAIL lzb_blank_slot%0d: lit cycles=%0d want 0", s, rec_lit[s]);
                end
            end
            checks++;
            if (f == 0 ? rec_seg[6] !== 8'h5B : rec_lit[6] != 0) begin
                failures++;
                $display("FAIL lzb_slot6: frame=%0d seg=%h lit=%0d", f, rec_seg[6], rec_lit[6]);
            end
            checks++;
            if (rec_seg[7] !== 8'h7E) begin
                failures++;
                $display("FAIL lzb_slot7: seg=%h want 7E", rec_seg[7]);
            end
        end
    endtask

    task automatic test_pwm();
        int want;
        for (int f = 0; f < 2; f++) begin
            wait_frame_start();
            data = 32'h8888_8888; bright = (f == 0) ? 4'd3 : 4'd0;
            en = 8'hFF; lzb = 1'b0; dp = 8'h00;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                checks++;
                if ({bus.num_scan_select, bus.num_seg7, bus_al.num_scan_select, bus_al.num_seg7}
                    !== {exp_sel, exp_seg, exp_sel, ~exp_seg}) begin
                    failures++;
                    $display("FAIL pwm_model: k=%0d sel=%h seg=%h want sel=%h seg=%h",
                             k, bus.num_scan_select, bus.num_seg7, exp_sel, exp_seg);
                end
            end
            #1;
            for (int s = 0; s < 8; s++) begin
                want = 0;
                for (int t = BLANK; t < DIV; t++)
                    if ((s * DIV + t) % 16 <= int'(bright)) want++;
                checks++;
                if (rec_lit[s] != want) begin
                    failures++;
                    $display("FAIL pwm_duty_slot%0d: bright=%0d lit=%0d want %0d",
                             s, bright, rec_lit[s], want);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        wait_frame_start();
        data = 32'h1111_1111; bright = 4'd15; en = 8'hFF;
        lzb = 1'b0; dp = 8'h00;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.num_scan_select, bus.num_seg7, bus_al.num_scan_select, bus_al.num_seg7}
                !== {exp_sel, exp_seg, exp_sel, ~exp_seg}) begin
                failures++;
                $display("FAIL snap_model: k=%0d sel=%h seg=%h want sel=%h seg=%h",
                         k, bus.num_scan_select, bus.num_seg7, exp_sel, exp_seg);
            end
            if (i == 3 * DIV + 10) data = 32'h2222_2222;
        end
        #1;
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (rec_seg[s] !== 8'h30) begin
                failures++;
                $display("FAIL snap_hold_slot%0d: seg=%h want 30", s, rec_seg[s]);
            end
        end
        wait_frame_start();
        for (int i = 0; i < FRAME; i++) @(negedge clk);
        #1;
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (rec_seg[s] !== 8'h6D) begin
                failures++;
                $display("FAIL snap_next_slot%0d: seg=%h want 6D", s, rec_seg[s]);
            end
        end
    endtask

    task automatic test_dp_en();
        for (int f = 0; f < 2; f++) begin
            wait_frame_start();
            data = 32'h0; lzb = 1'b0; bright = 4'd15;
            dp = (f == 0) ? 8'h01 : 8'h00;
            en = (f == 0) ? 8'hFF : 8'h0F;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                checks++;
                if ({bus.num_scan_select, bus.num_seg7, bus_al.num_scan_select, bus_al.num_seg7}
                    !== {exp_sel, exp_seg, exp_sel, ~exp_seg}) begin
                    failures++;
                    $display("FAIL dpen_model: k=%0d sel=%h seg=%h al_seg=%h want sel=%h seg=%h",
                             k, bus.num_scan_select, bus.num_seg7, bus_al.num_seg7, exp_sel, exp_seg);
                end
            end
            #1;
            checks++;
            if (f == 0 && (rec_seg[7] !== 8'hFE || rec_al[7] !== 8'h01)) begin
                failures++;
                $display("FAIL dp_slot7: seg=%h al_seg=%h want FE/01", rec_seg[7], rec_al[7]);
            end
            if (f == 1) begin
                for (int s = 0; s < 8; s++) begin
                    checks++;
                    if ((s < 4) ? rec_lit[s] != 0 : rec_lit[s] == 0) begin
                        failures++;
                        $display("FAIL en_slot%0d: lit cycles=%0d", s, rec_lit[s]);
                    end
                end
                checks++;
                if (rec_al[7] !== 8'h81) begin
                    failures++;
                    $display("FAIL active_low_slot7: al_seg=%h want 81", rec_al[7]);
                end
            end
        end
    endtask

    task automatic test_random();
        int mid;
        for (int f = 0; f < 6; f++) begin
            wait_frame_start();
            data = $urandom >> (4 * $urandom_range(0, 8));
            dp = 8'($urandom); en = 8'($urandom); lzb = 1'($urandom);
            bright = 4'($urandom);
            mid = $urandom_range(1, FRAME - 2);
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                checks++;
                if ({bus.num_scan_select, bus.num_seg7, bus_al.num_scan_select, bus_al.num_seg7}
                    !== {exp_sel, exp_seg, exp_sel, ~exp_seg}) begin
                    failures++;
                    $display("FAIL random_model: k=%0d sel=%h seg=%h al_seg=%h want sel=%h seg=%h",
                             k, bus.num_scan_select, bus.num_seg7, bus_al.num_seg7, exp_sel, exp_seg);
                end
                checks++;
                if ($countones(~bus.num_scan_select) > 1) begin
                    failures++;
                    $display("FAIL one_select: sel=%h has >1 active bit", bus.num_scan_select);
                end
                if (i == mid) begin
                    data = $urandom; dp = 8'($urandom); en = 8'($urandom);
                    lzb = 1'($urandom); bright = 4'($urandom);
                end
            end
        end
    endtask

    initial begin
        data = 32'h0123_89AB; dp = 8'h00; en = 8'hFF;
        lzb = 1'b0; bright = 4'd15; rst = 1'b1;
        test_reset();
        test_decode();
        test_lzb();
        test_pwm();
        test_snapshot();
        test_dp_en();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display driver. It shows an N_DIGITS-digit hex word on a common-anode scan bank. Compared with the existing fixed 8-digit scanner, it adds:
- a ghost-suppression blank interval
- PWM brightness control
- a per-digit enable mask and per-digit decimal points
- leading-zero blanking
- frame-coherent snapshotting of the displayed value

It sits between the CPU's display register and the board pins.

Parameters:
N_DIGITS, 8, number of digits scanned (1..16).
DIV_CNT, 150000, clk cycles per digit slot (>= BLANK_CYC+16).
BLANK_CYC, 1000, cycles at the start of each slot with all selects inactive (ghost guard).
SEG_ACTIVE_LOW, 0, 1 inverts all segment outputs for common-anode segment drive.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
data  in  4*N_DIGITS  hex value; nibble [4*N_DIGITS-1 -: 4] is leftmost digit
dp  in  N_DIGITS  decimal point per digit; bit N_DIGITS-1 = leftmost
digit_en  in  N_DIGITS  per-digit enable, same bit order
lzb  in  1  leading-zero blanking enable
bright  in  4  brightness 0..15 (15 = full on)
num_scan_select  out  N_DIGITS  digit selects, active-low; bit N_DIGITS-1 = leftmost
num_seg7  out  8  segments {dp,a,b,c,d,e,f,g} (bit7=dp, bit0=g), active-high unless SEG_ACTIVE_LOW

Behaviour:
- Reset: clk is the only clock. Reset is synchronous and active-high on rst; it overrides everything on the same edge.
  - tick_cnt=0, slot=0, pwm_cnt=0; snapshot regs cleared to 0.
  - num_scan_select = all ones.
  - num_seg7 = 8'h00 (8'hFF if SEG_ACTIVE_LOW).
  - rst asserted mid-frame aborts the frame; after release, scanning restarts at slot 0 with a new snapshot.
- tick_cnt: counts 0..DIV_CNT-1 and then wraps to 0. On wrap, slot advances; slot N_DIGITS-1 wraps to 0.
- pwm_cnt: 4-bit, increments every cycle and wraps 15->0. It is independent of slot.
- Snapshot: when tick_cnt==0 and slot==0 (frame start, including the first cycle after reset), data, dp, digit_en, lzb and bright are latched.
  - The whole frame displays the snapshot; input changes mid-frame are invisible until the next frame.
- Slot s displays digit index d = N_DIGITS-1-s: nibble snap_data[4*d+:4], select bit d. Slot 0 = leftmost digit.
- Leading-zero mask: digit d is a leading zero when snap_lzb=1, d>0, and all nibbles from d up to N_DIGITS-1 are 0. The rightmost digit (d=0) is never leading-zero blanked.
- Lit condition for the current slot: tick_cnt >= BLANK_CYC AND pwm_cnt <= snap_bright AND snap_digit_en[d] AND NOT leading_zero(d).
- Outputs are registered and computed from the current counters, so they lag the counters by 1 cycle.
  - Lit: select bit d = 0, all other select bits = 1; seg = {snap_dp[d], decode(nibble)}, XOR 8'hFF if SEG_ACTIVE_LOW.
  - Not lit: selects all ones; seg = blank value (the reset value).
- Decode (abcdefg): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- Duty and refresh: within a lit slot, duty = (bright+1)/16. Full frame period = N_DIGITS*DIV_CNT cycles.
- Invariant: at most one select bit is low in any cycle.

Decomposition:
- Package seg7_pkg:
  - 16-entry segment constant table (abcdefg)
  - SEG_BLANK constant
  - function for leading-zero detection over a parametrised width
- One combinational sub-module, hex_to_seg7 (4-bit nibble + dp -> 8-bit segments), reusable by other display blocks.
- Counters, snapshot logic and output registers live in the top module.

Test Plan:
All tests use N_DIGITS=8, DIV_CNT=40, BLANK_CYC=2, SEG_ACTIVE_LOW=0.
1. Reset: rst high 3 cycles mid-scan -> selects 8'hFF, seg 8'h00. After release, the first lit cycle is select 8'h7F at tick_cnt=2 (+1 latency).
2. data=32'h0123_89AB, bright=15, dp=0, digit_en=8'hFF, lzb=0:
   - selects 7F,BF,DF,EF,F7,FB,FD,FE in turn
   - segs 7E,30,6D,79,7F,7B,77,1F
   - 2 cycles of select FF at each slot start
3. lzb=1, data=32'h0000_0050 -> slots 0-5 select FF, slot 6 seg 5B, slot 7 seg 7E. With data=0, only slot 7 lights, seg 7E.
4. bright=3, data=32'h8888_8888 -> in each lit window, select active exactly 4 of every 16 consecutive cycles, aligned to pwm_cnt 0..3. bright=0 gives 1 of 16.
5. Change data from 32'h1111_1111 to 32'h2222_2222 during slot 3 -> slots 3-7 still show seg 30. The next frame shows 6D from slot 0.
6. dp=8'h01 with data=0 -> slot 7 seg 8'hFE. digit_en=8'h0F -> slots 0-3 select FF, slots 4-7 lit. With SEG_ACTIVE_LOW=1, blank seg = FF and digit 0 = 81.
